pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register that generalises the fetch/decode boundary register.
- Carries instruction, PC, valid and delay-slot flag from stage STAGE to stage STAGE+1 under the shared stall vector.
- Adds flush, a configurable NOP encoding, and a one-entry capture buffer so an instruction returned by synchronous instruction memory during a stall is not lost.
- Instantiated at IF/ID; reusable at any stage boundary.

---
 rtl/pipe_stage_reg.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage boundary register (e.g. IF/ID) with flush, bubble insertion and a
// one-entry capture buffer that keeps a synchronous-memory return alive across a stall.
// Optional bubble/flush performance counter: define PIPE_STAGE_PERF_EN.
// Legal STAGE range is 0..CTRL_W-2 (STAGE+1 must index the downstream stall bit).

module pipe_stage_reg #(
  parameter int unsigned        INST_W   = 32,
  parameter int unsigned        PC_W     = 32,
  parameter int unsigned        CTRL_W   = 6,
  parameter int unsigned        STAGE    = 1,
  parameter logic [INST_W-1:0]  NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [INST_W-1:0] inst_in,
  input  logic              in_is_ds,
  output logic              out_valid,
  output logic [PC_W-1:0]   pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic              out_is_ds,
  output logic              buf_full,
  output logic [31:0]       bubble_cnt
);

  logic stall_here;
  logic stall_down;
  logic bubble;

  assign stall_here = stall[STAGE];
  assign stall_down = stall[STAGE+1];
  // This stage stalls while downstream keeps moving: a hole must be inserted.
  assign bubble     = stall_here & ~stall_down;

  // Only two bits of the shared stall vector matter to this boundary.
  logic unused_stall;
  assign unused_stall = ^stall;

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              ds_q, ds_d;

  logic              buf_full_q, buf_full_d;
  logic [PC_W-1:0]   buf_pc_q, buf_pc_d;
  logic [INST_W-1:0] buf_inst_q, buf_inst_d;
  logic              buf_ds_q, buf_ds_d;

  // Next-state for the output register and the capture buffer.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    ds_d       = ds_q;
    buf_full_d = buf_full_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    buf_ds_d   = buf_ds_q;

    if (flush) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      inst_d     = NOP_INST;
      ds_d       = 1'b0;
      buf_full_d = 1'b0;
    end else begin
      if (bubble) begin
        valid_d = 1'b0;
        pc_d    = '0;
        inst_d  = NOP_INST;
        ds_d    = 1'b0;
      end else if (!stall_here) begin
        if (buf_full_q) begin
          // Drain: the live inputs are dropped, upstream re-presents them next cycle.
          valid_d    = 1'b1;
          pc_d       = buf_pc_q;
          inst_d     = buf_inst_q;
          ds_d       = buf_ds_q;
          buf_full_d = 1'b0;
        end else begin
          valid_d = in_valid;
          pc_d    = pc_in;
          inst_d  = inst_in;
          ds_d    = in_is_ds;
        end
      end

      // Upstream holds its PC while stalled, so one entry is always enough.
      if (stall_here && in_valid && !buf_full_q) begin
        buf_full_d = 1'b1;
        buf_pc_d   = pc_in;
        buf_inst_d = inst_in;
        buf_ds_d   = in_is_ds;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      inst_q     <= NOP_INST;
      ds_q       <= 1'b0;
      buf_full_q <= 1'b0;
      buf_pc_q   <= '0;
      buf_inst_q <= NOP_INST;
      buf_ds_q   <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      ds_q       <= ds_d;
      buf_full_q <= buf_full_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      buf_ds_q   <= buf_ds_d;
    end
  end

  assign out_valid = valid_q;
  assign pc_out    = pc_q;
  assign inst_out  = inst_q;
  assign out_is_ds = ds_q;
  assign buf_full  = buf_full_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating count of cycles that insert a hole (flush or bubble).
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if ((flush || bubble) && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (STAGE=1, CTRL_W=6, NOP_INST=0).
// The reference keeps the output as a record and the capture buffer as a queue.

module tb_pipe_stage_reg;

  localparam logic [31:0] Nop = 32'h0;
  localparam longint unsigned CntMax = 64'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid;
  logic [31:0] pc_in;
  logic [31:0] inst_in;
  logic        in_is_ds;
  logic        out_valid;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        out_is_ds;
  logic        buf_full;
  logic [31:0] bubble_cnt;

  pipe_stage_reg #(
    .INST_W  (32),
    .PC_W    (32),
    .CTRL_W  (6),
    .STAGE   (1),
    .NOP_INST(Nop)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (in_valid),
    .pc_in     (pc_in),
    .inst_in   (inst_in),
    .in_is_ds  (in_is_ds),
    .out_valid (out_valid),
    .pc_out    (pc_out),
    .inst_out  (inst_out),
    .out_is_ds (out_is_ds),
    .buf_full  (buf_full),
    .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ds;
  } ent_t;

  ent_t            m_out;
  ent_t            m_buf[$];
  longint unsigned m_cnt;

  int checks = 0;
  int errors = 0;

  // Observed and expected state packed as {valid, pc, inst, ds, buf_full, bubble_cnt}.
  function automatic logic [98:0] obs();
    return {out_valid, pc_out, inst_out, out_is_ds, buf_full, bubble_cnt};
  endfunction

  function automatic logic [98:0] expv();
    logic [31:0] c;
`ifdef PIPE_STAGE_PERF_EN
    c = m_cnt[31:0];
`else
    c = 32'd0;
`endif
    return {m_out.v, m_out.pc, m_out.inst, m_out.ds, (m_buf.size() != 0), c};
  endfunction

  // Advance one clock: predict from the rules, then sample 1ns after the edge.
  task automatic cycle();
    ent_t nop;
    ent_t nxt;
    ent_t q[$];
    logic s, d;
    longint unsigned c;
    nop = '{v: 1'b0, pc: 32'h0, inst: Nop, ds: 1'b0};
    nxt = m_out;
    q   = m_buf;
    c   = m_cnt;
    s   = stall[1];
    d   = stall[2];
    if (!rst_n) begin
      nxt = nop;
      q.delete();
      c = 0;
    end else if (flush) begin
      nxt = nop;
      q.delete();
      if (c < CntMax) c++;
    end else begin
      if (s && !d) begin
        nxt = nop;
        if (c < CntMax) c++;
      end else if (!s) begin
        if (q.size() > 0) nxt = q.pop_front();
        else nxt = '{v: in_valid, pc: pc_in, inst: inst_in, ds: in_is_ds};
      end
      if (s && in_valid && q.size() == 0) q.push_back('{v: 1'b1, pc: pc_in, inst: inst_in, ds: in_is_ds});
    end
    @(posedge clk);
    #1;
    m_out = nxt;
    m_buf = q;
    m_cnt = c;
  endtask

  task automatic drive(input logic [5:0] st, input logic fl, input logic v,
                       input logic [31:0] pc, input logic [31:0] inst, input logic ds);
    stall    = st;
    flush    = fl;
    in_valid = v;
    pc_in    = pc;
    inst_in  = inst;
    in_is_ds = ds;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(6'b0, 1'b0, 1'b1, 32'h55, 32'hAA, 1'b1);
    cycle();
    checks++;
    if ({out_valid, pc_out, inst_out, out_is_ds, buf_full, bubble_cnt} !== {1'b0, 32'h0, Nop, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_values got=%h want=%h", obs(), {1'b0, 32'h0, Nop, 1'b0, 1'b0, 32'h0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    drive(6'b0, 1'b0, 1'b1, 32'h100, 32'h2408_0005, 1'b0);
    cycle();
    checks++;
    if ({out_valid, pc_out, inst_out} !== {1'b1, 32'h100, 32'h2408_0005}) begin
      errors++;
      $display("FAIL load got v=%b pc=%h inst=%h want v=1 pc=100 inst=24080005", out_valid, pc_out, inst_out);
    end
    drive(6'b0, 1'b0, 1'b1, 32'h104, 32'h1234_5678, 1'b1);
    cycle();
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL load_ds got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_bubble_capture();
    drive(6'b000010, 1'b0, 1'b1, 32'h108, 32'h3C01_1234, 1'b0);
    cycle();
    checks++;
    if ({out_valid, inst_out, buf_full} !== {1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL bubble got v=%b inst=%h buf=%b want v=0 inst=0 buf=1", out_valid, inst_out, buf_full);
    end
    drive(6'b0, 1'b0, 1'b1, 32'h10C, 32'hDEAD_BEEF, 1'b0);
    cycle();
    checks++;
    if ({out_valid, pc_out, inst_out, buf_full} !== {1'b1, 32'h108, 32'h3C01_1234, 1'b0}) begin
      errors++;
      $display("FAIL drain got v=%b pc=%h inst=%h buf=%b want v=1 pc=108 inst=3c011234 buf=0",
               out_valid, pc_out, inst_out, buf_full);
    end
    cycle();
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL after_drain got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_hold();
    drive(6'b0, 1'b0, 1'b1, 32'h100, 32'h2408_0005, 1'b0);
    cycle();
    drive(6'b000110, 1'b0, 1'b1, 32'h104, 32'h0000_0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({pc_out, out_valid, buf_full} !== {32'h100, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL hold[%0d] got pc=%h v=%b buf=%b want pc=100 v=1 buf=1", i, pc_out, out_valid, buf_full);
      end
    end
  endtask

  task automatic test_flush();
    // Buffer is full from test_hold; flush while fully stalled.
    drive(6'b000110, 1'b1, 1'b1, 32'h104, 32'h0000_0001, 1'b0);
    cycle();
    checks++;
    if ({out_valid, inst_out, pc_out, buf_full} !== {1'b0, Nop, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL flush got v=%b inst=%h pc=%h buf=%b want v=0 inst=0 pc=0 buf=0",
               out_valid, inst_out, pc_out, buf_full);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(6'b0, 1'b0, 1'b1, 32'h200, 32'hABCD_0001, 1'b1);
    cycle();
    drive(6'b000110, 1'b0, 1'b1, 32'h204, 32'hABCD_0002, 1'b0);
    cycle();
    checks++;
    if (buf_full !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_buf got=%b want=1", buf_full);
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    checks++;
    if ({out_valid, pc_out, inst_out, out_is_ds, buf_full, bubble_cnt} !== {1'b0, 32'h0, Nop, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid_stall got=%h want=%h", obs(), {1'b0, 32'h0, Nop, 1'b0, 1'b0, 32'h0});
    end
  endtask

  task automatic test_perf();
    logic [31:0] want;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive(6'b000010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle();
    cycle();
    drive(6'b000000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle();
`ifdef PIPE_STAGE_PERF_EN
    want = 32'd3;
`else
    want = 32'd0;
`endif
    checks++;
    if (bubble_cnt !== want) begin
      errors++;
      $display("FAIL perf_count got=%0d want=%0d", bubble_cnt, want);
    end
`ifdef PIPE_STAGE_PERF_EN
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_q;
    m_cnt = CntMax;
    drive(6'b000010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle();
    checks++;
    if (bubble_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL perf_saturate got=%h want=ffffffff", bubble_cnt);
    end
`endif
    drive(6'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0] st;
    for (int i = 0; i < 400; i++) begin
      st = 6'($urandom);
      // Bias toward running so the buffer fills and drains often.
      if ($urandom_range(0, 2) == 0) st[2:1] = 2'b00;
      drive(st, ($urandom_range(0, 15) == 0), 1'($urandom), $urandom, $urandom, 1'($urandom));
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random[%0d] got=%h want=%h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    m_out = '0;
    m_cnt = 0;
    rst_n = 1'b0;
    drive(6'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_load();
    test_bubble_capture();
    test_hold();
    test_flush();
    test_reset_mid_stall();
    test_perf();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
